// File: rtl/pll_reconfig_pkg.sv
// pll_reconfig_pkg: reconfig register map, counter-word fields, sequencer states, C data-word builder
package pll_reconfig_pkg;
    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;
    localparam logic [5:0] ADDR_K     = 6'h07;
    localparam logic [5:0] ADDR_BW    = 6'h08;
    localparam logic [5:0] ADDR_CP    = 6'h09;
    localparam int LO_OFS  = 0;
    localparam int HI_OFS  = 8;
    localparam int BYP_OFS = 16;
    localparam int ODD_OFS = 17;
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_WR,
        ST_START,
        ST_WAIT_LOCK
    } seq_state_t;
    function automatic logic [31:0] c_word(input logic [4:0] idx, input logic [17:0] word);
        return {9'b0, idx, word};
    endfunction
endpackage

// File: rtl/pll_hdmi_reconfig_seq.sv
// pll_hdmi_reconfig_seq: writes changed PLL counters, starts reconfig, waits for lock; PLL_LOCK_TIMEOUT_EN adds lock timeout
module pll_hdmi_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_CLK = 1,
    parameter int LOCK_STABLE = 1024
`ifdef PLL_LOCK_TIMEOUT_EN
    , parameter int LOCK_TIMEOUT = 2**20
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [17:0]            cfg_n,
    input  logic [17:0]            cfg_m,
    input  logic [31:0]            cfg_k,
    input  logic [18*NUM_CLK-1:0]  cfg_c,
    input  logic [3:0]             cfg_bw,
    input  logic [2:0]             cfg_cp,
    output logic [5:0]             mgmt_address,
    output logic                   mgmt_write,
    output logic [31:0]            mgmt_writedata,
    input  logic                   mgmt_waitrequest,
    input  logic                   pll_locked,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int NENT = NUM_CLK + 5;
    localparam int IW = $clog2(NENT + 1);
    localparam int LW = $clog2(LOCK_STABLE + 1);
    seq_state_t state;
    logic [IW-1:0] idx;
    logic [4:0] cidx;
    logic [17:0] pend_n, pend_m;
    logic [31:0] pend_k;
    logic [18*NUM_CLK-1:0] pend_c;
    logic [3:0] pend_bw;
    logic [2:0] pend_cp;
    logic [31:0] shadow [NENT];
    logic shadow_valid;
    logic [5:0] ent_addr;
    logic [31:0] ent_data;
    logic skip;
    logic [LW-1:0] lock_cnt;
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign error = 1'b0;
`endif
    always_comb begin
        cidx = 5'(idx) - 5'd3;
        ent_addr = ADDR_CP;
        ent_data = {29'b0, pend_cp};
        case (idx)
            IW'(0): begin ent_addr = ADDR_N; ent_data = {14'b0, pend_n}; end
            IW'(1): begin ent_addr = ADDR_M; ent_data = {14'b0, pend_m}; end
            IW'(2): begin ent_addr = ADDR_K; ent_data = pend_k; end
            default: begin
                ent_addr = idx < IW'(NUM_CLK + 3) ? ADDR_C : idx == IW'(NUM_CLK + 3) ? ADDR_BW : ADDR_CP;
                ent_data = idx < IW'(NUM_CLK + 3) ? c_word(cidx, pend_c[cidx*18 +: 18]) :
                           idx == IW'(NUM_CLK + 3) ? {28'b0, pend_bw} : {29'b0, pend_cp};
            end
        endcase
        skip = shadow_valid && ent_data == shadow[idx];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            idx <= '0;
            cfg_ready <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            mgmt_write <= 1'b0;
            mgmt_address <= '0;
            mgmt_writedata <= '0;
            shadow_valid <= 1'b0;
            lock_cnt <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
            error <= 1'b0;
            tmo_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
            error <= 1'b0;
`endif
            case (state)
                ST_INIT: begin
                    if (!mgmt_write) begin
                        mgmt_address <= ADDR_MODE;
                        mgmt_writedata <= '0;
                        mgmt_write <= 1'b1;
                    end else if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        cfg_ready <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: if (cfg_valid) begin
                    pend_n <= cfg_n;
                    pend_m <= cfg_m;
                    pend_k <= cfg_k;
                    pend_c <= cfg_c;
                    pend_bw <= cfg_bw;
                    pend_cp <= cfg_cp;
                    cfg_ready <= 1'b0;
                    busy <= 1'b1;
                    idx <= '0;
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (idx == IW'(NENT)) begin
                        mgmt_address <= ADDR_START;
                        mgmt_writedata <= '0;
                        mgmt_write <= 1'b1;
                        state <= ST_START;
                    end else if (skip) begin
                        idx <= idx + 1'b1;
                    end else begin
                        mgmt_address <= ent_addr;
                        mgmt_writedata <= ent_data;
                        mgmt_write <= 1'b1;
                        state <= ST_WR;
                    end
                end
                ST_WR: if (!mgmt_waitrequest) begin
                    mgmt_write <= 1'b0;
                    shadow[idx] <= mgmt_writedata;
                    idx <= idx + 1'b1;
                    state <= ST_LOAD;
                end
                ST_START: if (!mgmt_waitrequest) begin
                    mgmt_write <= 1'b0;
                    lock_cnt <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    lock_cnt <= pll_locked ? lock_cnt + 1'b1 : '0;
`ifdef PLL_LOCK_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    if (pll_locked && lock_cnt == LW'(LOCK_STABLE - 1)) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        shadow_valid <= 1'b1;
                        cfg_ready <= 1'b1;
                        state <= ST_IDLE;
                    end
`ifdef PLL_LOCK_TIMEOUT_EN
                    else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        error <= 1'b1;
                        busy <= 1'b0;
                        shadow_valid <= 1'b0;
                        cfg_ready <= 1'b1;
                        state <= ST_IDLE;
                    end
`endif
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_hdmi_reconfig_seq.sv
// tb_pll_hdmi_reconfig_seq: directed vectors against the PLL reconfig sequencer
module tb_pll_hdmi_reconfig_seq;
  logic clk = 0, rst = 1, cfg_valid = 0, cfg_ready;
  logic [17:0] cfg_n = 0, cfg_m = 0, cfg_c = 0;
  logic [31:0] cfg_k = 0;
  logic [3:0] cfg_bw = 0;
  logic [2:0] cfg_cp = 0;
  logic [5:0] mgmt_address;
  logic mgmt_write, mgmt_waitrequest = 0, pll_locked = 1, busy, done, error;
  logic [31:0] mgmt_writedata;
  int passed = 0, total = 0, cyc = 0;
  logic [37:0] wlog[$], exp_q[$];
  int start_cyc, done_cyc, err_cyc, stall_n, g0;
  logic start_seen, done_seen, err_seen, stall_en = 0, prev_xfer = 0;
  logic [31:0] stall_exp_d;
`ifdef PLL_LOCK_TIMEOUT_EN
  pll_hdmi_reconfig_seq #(.LOCK_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c),
    .cfg_bw(cfg_bw), .cfg_cp(cfg_cp), .mgmt_address(mgmt_address),
    .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
    .busy(busy), .done(done), .error(error)
  );
`else
  pll_hdmi_reconfig_seq dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c),
    .cfg_bw(cfg_bw), .cfg_cp(cfg_cp), .mgmt_address(mgmt_address),
    .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
    .busy(busy), .done(done), .error(error)
  );
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (stall_en && mgmt_write && mgmt_address == 6'h04 && stall_n < 7) begin
      mgmt_waitrequest = 1;
      chk("stall_addr", mgmt_address, 6'h04);
      chk("stall_data", mgmt_writedata, stall_exp_d);
      stall_n++;
    end else mgmt_waitrequest = 0;
    if (!rst && mgmt_write) chk("write_gap", prev_xfer, 0);
    if (!rst && mgmt_write && !mgmt_waitrequest) begin
      wlog.push_back({mgmt_address, mgmt_writedata});
      if (mgmt_address == 6'h02) begin start_cyc = cyc; start_seen = 1; end
      prev_xfer = 1;
    end else prev_xfer = 0;
    if (done) begin
      done_seen = 1; done_cyc = cyc;
      chk("busy_at_done", busy, 0);
      chk("err_at_done", error, 0);
    end
    if (error) begin err_seen = 1; err_cyc = cyc; chk("busy_at_err", busy, 0); end
  end
  task automatic req(input logic [17:0] n, m, input logic [31:0] k, input logic [17:0] c,
                     input logic [3:0] bw, input logic [2:0] cp);
    for (int t = 0; t < 5000 && !cfg_ready; t++) begin @(posedge clk); #1; end
    chk("ready_idle", cfg_ready, 1);
    cfg_n = n; cfg_m = m; cfg_k = k; cfg_c = c; cfg_bw = bw; cfg_cp = cp;
    start_seen = 0; done_seen = 0; err_seen = 0;
    cfg_valid = 1;
    @(posedge clk); #1;
    cfg_valid = 0;
    chk("busy_after_xfer", busy, 1);
    chk("ready_low_busy", cfg_ready, 0);
  endtask
  task automatic wait_done(input string tag);
    for (int t = 0; t < 5000 && !done_seen; t++) begin @(posedge clk); #1; end
    chk({tag, "_done"}, done_seen, 1);
  endtask
  task automatic cmp_log(input string tag);
    chk({tag, "_nwr"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wlog[i], exp_q[i]);
    exp_q.delete();
    wlog.delete();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_write", mgmt_write, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    wlog.delete();
    rst = 0;
    req(18'h10000, 18'h00404, 32'd3908420153, 18'h00303, 4'h6, 3'h2);
    wait_done("t1");
    exp_q = '{{6'h00, 32'h0}, {6'h03, 32'h00010000}, {6'h04, 32'h00000404},
              {6'h07, 32'hE8F5C239}, {6'h05, 32'h00000303}, {6'h08, 32'h6},
              {6'h09, 32'h2}, {6'h02, 32'h0}};
    cmp_log("t1");
    chk("t1_lock_cycles", done_cyc - start_cyc, 1025);
    req(18'h10000, 18'h00404, 32'd3908420153, 18'h00303, 4'h6, 3'h2);
    wait_done("t2");
    exp_q = '{{6'h02, 32'h0}};
    cmp_log("t2");
    chk("t2_lock_cycles", done_cyc - start_cyc, 1025);
    req(18'h10000, 18'h00404, 32'd3908420153, 18'h00505, 4'h6, 3'h2);
    wait_done("t3");
    exp_q = '{{6'h05, 32'h00000505}, {6'h02, 32'h0}};
    cmp_log("t3");
    stall_en = 1; stall_n = 0; stall_exp_d = 32'h00000504;
    req(18'h10000, 18'h00504, 32'd3908420153, 18'h00505, 4'h6, 3'h2);
    wait_done("t4");
    stall_en = 0;
    chk("t4_stall_cycles", stall_n, 7);
    exp_q = '{{6'h04, 32'h00000504}, {6'h02, 32'h0}};
    cmp_log("t4");
    req(18'h10000, 18'h00504, 32'd3908420153, 18'h00505, 4'h6, 3'h2);
    for (int t = 0; t < 200 && !start_seen; t++) begin @(posedge clk); #1; end
    chk("t5_start_seen", start_seen, 1);
    repeat (500) @(posedge clk);
    #1;
    g0 = cyc;
    pll_locked = 0;
    @(posedge clk); #1;
    pll_locked = 1;
    wait_done("t5");
    chk("t5_done_cycle", done_cyc, g0 + 1 + 1024);
    exp_q = '{{6'h02, 32'h0}};
    cmp_log("t5");
    stall_en = 1; stall_n = 0; stall_exp_d = 32'h00000606;
    req(18'h10000, 18'h00606, 32'd3908420153, 18'h00505, 4'h6, 3'h2);
    for (int t = 0; t < 50 && !(mgmt_write && mgmt_address == 6'h04); t++) begin @(posedge clk); #1; end
    chk("t6_m_write_seen", mgmt_write, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("t6_write_drop", mgmt_write, 0);
    chk("t6_busy_drop", busy, 0);
    @(posedge clk); #1;
    stall_en = 0;
    wlog.delete();
    rst = 0;
    req(18'h10000, 18'h00606, 32'd3908420153, 18'h00505, 4'h6, 3'h2);
    wait_done("t6");
    exp_q = '{{6'h00, 32'h0}, {6'h03, 32'h00010000}, {6'h04, 32'h00000606},
              {6'h07, 32'hE8F5C239}, {6'h05, 32'h00000505}, {6'h08, 32'h6},
              {6'h09, 32'h2}, {6'h02, 32'h0}};
    cmp_log("t6");
`ifdef PLL_LOCK_TIMEOUT_EN
    pll_locked = 0;
    req(18'h10000, 18'h00606, 32'd3908420153, 18'h00303, 4'h6, 3'h2);
    for (int t = 0; t < 1000 && !err_seen; t++) begin @(posedge clk); #1; end
    chk("t7_err_seen", err_seen, 1);
    chk("t7_err_cycle", err_cyc - start_cyc, 101);
    chk("t7_no_done", done_seen, 0);
    wlog.delete();
    pll_locked = 1;
    req(18'h10000, 18'h00606, 32'd3908420153, 18'h00303, 4'h6, 3'h2);
    wait_done("t7");
    exp_q = '{{6'h03, 32'h00010000}, {6'h04, 32'h00000606}, {6'h07, 32'hE8F5C239},
              {6'h05, 32'h00000303}, {6'h08, 32'h6}, {6'h09, 32'h2}, {6'h02, 32'h0}};
    cmp_log("t7");
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
